reg_desp_ctrl: RTL and testbench

REG_DESP_CTRL -- requirements
Module: reg_desp_ctrl

---
 rtl/reg_desp_ctrl_pkg.sv | 23 ++
 rtl/cont_bits.sv | 34 +++
 rtl/reg_desp_ctrl.sv | 122 ++++++++++++
 tb/tb_reg_desp_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_desp_ctrl_pkg.sv
// Shared definitions for the shift-register controller and the register it drives:
// register operating modes and controller state encoding.
package reg_desp_ctrl_pkg;

    // Register operating modes presented on MODO32
    localparam logic [1:0] MODO_DESP  = 2'b00;  // shift, vacated bit takes S_IN32
    localparam logic [1:0] MODO_ROT   = 2'b01;  // rotate, outgoing bit re-enters
    localparam logic [1:0] MODO_CARGA = 2'b10;  // parallel load from D32

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Mode used while bits are streamed out
    function automatic logic [1:0] stream_mode(input logic rot);
        return rot ? MODO_ROT : MODO_DESP;
    endfunction

endpackage

// File: rtl/cont_bits.sv
// Remaining-bit counter: loads the transfer length, counts down once per
// consumed bit and flags the empty and last-bit conditions.
module cont_bits #(
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] count;

    // Clear beats load beats decrement; never wraps below zero
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/reg_desp_ctrl.sv
// Controller for a parallel-load shift register: loads a word, then streams
// up to WIDTH bits out through a ready/valid serial port, with abort support.
module reg_desp_ctrl
    import reg_desp_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA,
    input  logic [CNT_W-1:0] NBITS,
    input  logic             DIR,
    input  logic             ROT,
    input  logic             FILL,
    input  logic             ABORT,
    input  logic             SER_READY,
    input  logic             S_OUT32,
    output logic             ENB32,
    output logic             DIR32,
    output logic             S_IN32,
    output logic [1:0]       MODO32,
    output logic [WIDTH-1:0] D32,
    output logic             SER_BIT,
    output logic             SER_VALID,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state;
    logic             rot_lat;
    logic             in_shift;
    logic             accept;
    logic             consume;
    logic             cnt_zero;
    logic             cnt_last;
    logic [CNT_W-1:0] nbits_clamped;

    assign in_shift      = (state == ST_SHIFT);
    assign nbits_clamped = (NBITS > WIDTH_C) ? WIDTH_C : NBITS;
    // A new transfer is only taken from IDLE, with a non-empty length, and never under abort
    assign accept        = (state == ST_IDLE) && START && (NBITS != '0) && !ABORT;
    // A bit leaves only when the sink takes it; abort cancels the cycle's bit
    assign consume       = in_shift && SER_READY && !ABORT;

    // Register enable: the load cycle, plus every consumed bit; abort freezes the register
    assign ENB32     = !ABORT && ((state == ST_LOAD) || (in_shift && SER_READY));
    assign SER_VALID = in_shift;
    assign SER_BIT   = in_shift & S_OUT32;

    cont_bits #(
        .CNT_W (CNT_W)
    ) u_cont_bits (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .clr      (ABORT),
        .load     (accept),
        .load_val (nbits_clamped),
        .dec      (consume),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Transfer sequencing with registered register controls, BUSY and DONE
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state   <= ST_IDLE;
            rot_lat <= 1'b0;
            DIR32   <= 1'b0;
            S_IN32  <= 1'b0;
            MODO32  <= MODO_DESP;
            D32     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else if (ABORT) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (accept) begin
                        state   <= ST_LOAD;
                        D32     <= DATA;
                        DIR32   <= DIR;
                        S_IN32  <= FILL;
                        rot_lat <= ROT;
                        MODO32  <= MODO_CARGA;
                        BUSY    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state  <= ST_SHIFT;
                    MODO32 <= stream_mode(rot_lat);
                end
                ST_SHIFT: begin
                    // cnt_zero cannot occur here in normal operation; it only guards
                    // against a stuck transfer if the counter were ever empty
                    if ((consume && cnt_last) || cnt_zero) begin
                        state <= ST_FIN;
                        DONE  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_desp_ctrl.sv
module tb_reg_desp_ctrl;

    localparam int W = 32;
    localparam int CW = 6;

    logic          CLK = 1'b0;
    logic          RESET_L = 1'b0;
    logic          START = 1'b0;
    logic [W-1:0]  DATA = '0;
    logic [CW-1:0] NBITS = '0;
    logic          DIR = 1'b0;
    logic          ROT = 1'b0;
    logic          FILL = 1'b0;
    logic          ABORT = 1'b0;
    logic          SER_READY = 1'b1;
    logic          S_OUT32;
    logic          ENB32;
    logic          DIR32;
    logic          S_IN32;
    logic [1:0]    MODO32;
    logic [W-1:0]  D32;
    logic          SER_BIT;
    logic          SER_VALID;
    logic          BUSY;
    logic          DONE;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    reg_desp_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .START     (START),
        .DATA      (DATA),
        .NBITS     (NBITS),
        .DIR       (DIR),
        .ROT       (ROT),
        .FILL      (FILL),
        .ABORT     (ABORT),
        .SER_READY (SER_READY),
        .S_OUT32   (S_OUT32),
        .ENB32     (ENB32),
        .DIR32     (DIR32),
        .S_IN32    (S_IN32),
        .MODO32    (MODO32),
        .D32       (D32),
        .SER_BIT   (SER_BIT),
        .SER_VALID (SER_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    logic [W-1:0] sreg = '0;
    always @(posedge CLK) begin
        if (ENB32) begin
            case (MODO32)
                2'b10:   sreg <= D32;
                2'b00:   sreg <= DIR32 ? {sreg[W-2:0], S_IN32} : {S_IN32, sreg[W-1:1]};
                2'b01:   sreg <= DIR32 ? {sreg[W-2:0], sreg[W-1]} : {sreg[0], sreg[W-1:1]};
                default: sreg <= sreg;
            endcase
        end
    end
    assign S_OUT32 = DIR32 ? sreg[W-1] : sreg[0];

    function automatic logic exp_bit(input logic [31:0] d, input int i, input logic dir);
        return dir ? d[31-i] : d[i];
    endfunction

    function automatic logic [31:0] exp_reg(input logic [31:0] d, input int n,
                                            input logic dir, input logic rot, input logic fill);
        logic [63:0] x;
        logic [63:0] m;
        logic [63:0] r;
        x = {32'b0, d};
        m = 64'hFFFF_FFFF;
        if (dir)
            r = rot ? ((x << n) | (x >> (32 - n))) : ((x << n) | (fill ? ((64'd1 << n) - 64'd1) : 64'd0));
        else
            r = rot ? ((x >> n) | (x << (32 - n))) : ((x >> n) | (fill ? (m & ~(m >> n)) : 64'd0));
        return r[31:0];
    endfunction

    task automatic xfer(input logic [31:0] data, input int nbits, input logic dir,
                        input logic rot, input logic fill, input int mode);
        int n;
        int got;
        int scyc;
        bit fin;
        n = (nbits > 32) ? 32 : nbits;
        START = 1'b1; DATA = data; NBITS = CW'(nbits); DIR = dir; ROT = rot; FILL = fill;
        SER_READY = 1'b1; ABORT = 1'b0;
        @(posedge CLK); #1;
        START = 1'($urandom_range(1)); DATA = $urandom; NBITS = CW'($urandom_range(1, 40));
        DIR = 1'($urandom_range(1)); ROT = 1'($urandom_range(1)); FILL = 1'($urandom_range(1));
        #1;
        chk("load_busy", BUSY, 1'b1);
        chk("load_enb", ENB32, 1'b1);
        chk("load_modo", MODO32, 2'b10);
        chk("load_d32", D32, data);
        chk("load_valid", SER_VALID, 1'b0);
        chk("load_done", DONE, 1'b0);
        got = 0; scyc = 0; fin = 0;
        while (!fin && scyc < 200) begin
            @(posedge CLK); #1;
            case (mode)
                0:       SER_READY = 1'b1;
                1:       SER_READY = ($urandom_range(99) >= 30);
                default: SER_READY = !(scyc >= 2 && scyc <= 4);
            endcase
            START = 1'($urandom_range(1)); DATA = $urandom; NBITS = CW'($urandom_range(40));
            #1;
            if (got == n) begin
                chk("fin_done", DONE, 1'b1);
                chk("fin_busy", BUSY, 1'b1);
                chk("fin_enb", ENB32, 1'b0);
                chk("fin_valid", SER_VALID, 1'b0);
                chk("fin_reg", sreg, exp_reg(data, n, dir, rot, fill));
                fin = 1;
            end else begin
                chk("sh_valid", SER_VALID, 1'b1);
                chk("sh_done", DONE, 1'b0);
                chk("sh_busy", BUSY, 1'b1);
                chk("sh_bit", SER_BIT, exp_bit(data, got, dir));
                chk("sh_enb", ENB32, SER_READY);
                chk("sh_modo", MODO32, (rot ? 2'b01 : 2'b00));
                chk("sh_dir32", DIR32, dir);
                chk("sh_sin32", S_IN32, fill);
                chk("sh_d32", D32, data);
                if (SER_READY) got++;
            end
            scyc++;
        end
        if (!fin) chk("done_timeout", DONE, 1'b1);
        @(posedge CLK); #1;
        START = 1'b0; SER_READY = 1'b1;
        #1;
        chk("post_busy", BUSY, 1'b0);
        chk("post_done", DONE, 1'b0);
        chk("post_enb", ENB32, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        @(posedge CLK); #1;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_enb", ENB32, 1'b0);
        chk("rst_modo", MODO32, 2'b00);
        chk("rst_d32", D32, 32'h0);
        chk("rst_valid", SER_VALID, 1'b0);
        @(negedge CLK);
        RESET_L = 1'b1;

        xfer(32'hA500_0000, 8, 1'b1, 1'b0, 1'b0, 0);
        xfer(32'h0000_000F, 40, 1'b0, 1'b0, 1'b0, 0);
        xfer(32'h0000_000A, 4, 1'b0, 1'b0, 1'b1, 2);
        xfer(32'h8000_0001, 32, 1'b1, 1'b1, 1'b0, 0);

        d = 32'hC3C3_0000;
        START = 1'b1; DATA = d; NBITS = 6'd8; DIR = 1'b1; ROT = 1'b0; FILL = 1'b0; SER_READY = 1'b1;
        @(posedge CLK); #1; START = 1'b0; #1;
        chk("ab_load", BUSY, 1'b1);
        @(posedge CLK); #2;
        chk("ab_bit0", SER_BIT, d[31]);
        @(posedge CLK); #1; START = 1'b1; DATA = 32'h1234_5678; NBITS = 6'd5; #1;
        chk("ab_bit1", SER_BIT, d[30]);
        @(posedge CLK); #1; ABORT = 1'b1; START = 1'b1; #1;
        chk("ab_d32", D32, d);
        chk("ab_bit2", SER_BIT, d[29]);
        chk("ab_enb", ENB32, 1'b0);
        @(posedge CLK); #1; ABORT = 1'b0; START = 1'b0; #1;
        chk("ab_idle_busy", BUSY, 1'b0);
        chk("ab_idle_valid", SER_VALID, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #2;
            chk("ab_no_done", DONE, 1'b0);
            chk("ab_stay_idle", BUSY, 1'b0);
        end

        START = 1'b1; DATA = 32'hFFFF_0000; NBITS = 6'd10; DIR = 1'b1; ROT = 1'b0; FILL = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET_L = 1'b0; #1;
        chk("mr_enb", ENB32, 1'b0);
        chk("mr_dir32", DIR32, 1'b0);
        chk("mr_sin32", S_IN32, 1'b0);
        chk("mr_modo", MODO32, 2'b00);
        chk("mr_d32", D32, 32'h0);
        chk("mr_valid", SER_VALID, 1'b0);
        chk("mr_bit", SER_BIT, 1'b0);
        chk("mr_busy", BUSY, 1'b0);
        chk("mr_done", DONE, 1'b0);
        @(negedge CLK); RESET_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #2;
            chk("mr_no_done", DONE, 1'b0);
            chk("mr_idle", BUSY, 1'b0);
        end
        START = 1'b1; NBITS = 6'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #2;
            chk("z_idle", BUSY, 1'b0);
            chk("z_no_done", DONE, 1'b0);
            chk("z_enb", ENB32, 1'b0);
        end
        START = 1'b0;

        for (int t = 0; t < 14; t++) begin
            xfer($urandom, int'($urandom_range(1, 40)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
